fft_frame_writer: RTL

- Upstream stage of the waterfall shared memory; owns the write side of the banked frame RAM.
- Accepts one FFT magnitude frame per transform and peak-holds groups of DECIM adjacent bins into one display bin.
- Scales and saturates each display bin to a pixel and writes it to the bank/address slot of the current frame.
- Maintains the circular frame index and publishes oldest_fft_idx to the read-side address generator.

---
 rtl/wf_mem_pkg.sv | 39 +++
 rtl/fft_frame_writer_if.sv | 28 ++
 rtl/peak_hold_group.sv | 81 ++++++++
 rtl/fft_frame_writer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/wf_mem_pkg.sv
// Shared layout of the waterfall frame RAM: geometry constants, slot mapping and
// writer FSM states. The read-side address generator uses the same mapping functions.
package wf_mem_pkg;

  localparam int unsigned NO_BANKS       = 2;
  localparam int unsigned RAM_ADDR_WIDTH = 12;
  localparam int unsigned NO_FFTS        = 50;
  localparam int unsigned BIN_BITS       = 7;
  localparam int unsigned DECIM          = 4;
  localparam int unsigned IN_W           = 16;
  localparam int unsigned DATAW          = 8;
  localparam int unsigned SHIFT          = 8;

  localparam int unsigned SLOT_BITS = RAM_ADDR_WIDTH - BIN_BITS;
  localparam int unsigned FFT_N     = DECIM * (2 ** BIN_BITS);

  typedef enum logic [1:0] {
    ACTIVE,
    DISCARD_FRZ,
    DISCARD_OVF
  } wr_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Low slot bits select the region inside a bank, high slot bits select the bank.
  function automatic int unsigned map_addr(input int unsigned idx, input int unsigned bin,
                                           input int unsigned slot_bits,
                                           input int unsigned bin_bits);
    return ((idx % (2 ** slot_bits)) << bin_bits) | bin;
  endfunction

  function automatic int unsigned map_bank(input int unsigned idx,
                                           input int unsigned slot_bits);
    return idx >> slot_bits;
  endfunction

endpackage

// File: rtl/fft_frame_writer_if.sv
// Sample stream in and RAM write port out of the frame writer.
interface fft_frame_writer_if #(
  parameter int unsigned IN_W           = 16,
  parameter int unsigned NO_BANKS       = 2,
  parameter int unsigned RAM_ADDR_WIDTH = 12,
  parameter int unsigned DATAW          = 8
);
  logic                      s_valid;
  logic                      s_ready;
  logic [IN_W-1:0]           s_data;
  logic                      s_last;
  logic                      wr_en;
  logic [NO_BANKS-1:0]       wr_bank_select;
  logic [RAM_ADDR_WIDTH-1:0] wr_address;
  logic [DATAW-1:0]          wr_data;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready,
    input  wr_en, wr_bank_select, wr_address, wr_data
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready,
    output wr_en, wr_bank_select, wr_address, wr_data
  );
endinterface

// File: rtl/peak_hold_group.sv
// Peak-holds DECIM consecutive samples, scales/saturates the peak to a pixel and
// registers the RAM write for the group one cycle after its last sample.
module peak_hold_group
  import wf_mem_pkg::*;
#(
  parameter int unsigned IN_W           = 16,
  parameter int unsigned DATAW          = 8,
  parameter int unsigned SHIFT          = 8,
  parameter int unsigned DECIM          = 4,
  parameter int unsigned BIN_BITS       = 7,
  parameter int unsigned RAM_ADDR_WIDTH = 12,
  parameter int unsigned NO_BANKS       = 2,
  parameter int unsigned IDX_W          = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sample,
  input  logic [IN_W-1:0]           data,
  input  logic                      frame_end,
  input  logic [BIN_BITS-1:0]       bin,
  input  logic [IDX_W-1:0]          wr_idx,
  output logic                      wr_en,
  output logic [NO_BANKS-1:0]       wr_bank_select,
  output logic [RAM_ADDR_WIDTH-1:0] wr_address,
  output logic [DATAW-1:0]          wr_data
);
  localparam int unsigned PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned SLOT_W = RAM_ADDR_WIDTH - BIN_BITS;

  logic [PH_W-1:0]           phase_q;
  logic [IN_W-1:0]           max_q;
  logic [IN_W-1:0]           grp_max;
  logic [IN_W-1:0]           scaled;
  logic [DATAW-1:0]          pixel;
  logic                      first;
  logic                      group_end;
  logic [RAM_ADDR_WIDTH-1:0] addr;
  logic [NO_BANKS-1:0]       bank;
  logic                      wr_en_q;
  logic [NO_BANKS-1:0]       bank_q;
  logic [RAM_ADDR_WIDTH-1:0] addr_q;
  logic [DATAW-1:0]          data_q;

  assign first     = (phase_q == '0);
  // A short frame closes its partial group early.
  assign group_end = frame_end | (phase_q == PH_W'(DECIM - 1));
  assign grp_max   = (first || data > max_q) ? data : max_q;
  assign scaled    = grp_max >> SHIFT;
  assign pixel     = (scaled > IN_W'({DATAW{1'b1}})) ? '1 : scaled[DATAW-1:0];

  assign addr = RAM_ADDR_WIDTH'(map_addr(32'(wr_idx), 32'(bin), SLOT_W, BIN_BITS));
  assign bank = NO_BANKS'(1) << map_bank(32'(wr_idx), SLOT_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      max_q   <= '0;
      wr_en_q <= 1'b0;
      bank_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      wr_en_q <= sample & group_end;
      if (sample) begin
        max_q   <= grp_max;
        phase_q <= group_end ? '0 : phase_q + 1'b1;
      end
      if (sample && group_end) begin
        bank_q <= bank;
        addr_q <= addr;
        data_q <= pixel;
      end
    end
  end

  assign wr_en          = wr_en_q;
  assign wr_bank_select = bank_q;
  assign wr_address     = addr_q;
  assign wr_data        = data_q;

endmodule

// File: rtl/fft_frame_writer.sv
// Write side of the banked waterfall RAM: frames FFT magnitudes into display bins,
// tracks the circular frame index and flags short/long frames.
module fft_frame_writer
  import wf_mem_pkg::*;
#(
  parameter int unsigned NO_BANKS       = wf_mem_pkg::NO_BANKS,
  parameter int unsigned RAM_ADDR_WIDTH = wf_mem_pkg::RAM_ADDR_WIDTH,
  parameter int unsigned NO_FFTS        = wf_mem_pkg::NO_FFTS,
  parameter int unsigned BIN_BITS       = wf_mem_pkg::BIN_BITS,
  parameter int unsigned DECIM          = wf_mem_pkg::DECIM,
  parameter int unsigned IN_W           = wf_mem_pkg::IN_W,
  parameter int unsigned DATAW          = wf_mem_pkg::DATAW,
  parameter int unsigned SHIFT          = wf_mem_pkg::SHIFT
) (
  input  logic                              clk,
  input  logic                              rst_n,
  fft_frame_writer_if.slave                 bus,
  input  logic                              freeze,
  input  logic                              err_clr,
  output logic [idx_width(NO_FFTS)-1:0]     oldest_fft_idx,
  output logic                              frame_done,
  output logic                              err_short,
  output logic                              err_long
);
  localparam int unsigned IDX_W     = idx_width(NO_FFTS);
  localparam int unsigned FRAME_LEN = DECIM * (2 ** BIN_BITS);
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN);

  wr_state_e          state_q, state_d;
  logic [CNT_W-1:0]   samp_cnt_q, samp_cnt_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]   oldest_q;
  logic               ready_q;
  logic               commit_pend_q;
  logic               frame_done_q;
  logic               err_short_q;
  logic               err_long_q;
  logic               accept;
  logic               at_last_samp;
  logic               keep;
  logic               frame_end;
  logic               set_short;
  logic               set_long;
  logic [BIN_BITS-1:0] bin;

  assign accept       = bus.s_valid & ready_q;
  assign at_last_samp = (samp_cnt_q == CNT_W'(FRAME_LEN - 1));
  assign bin          = BIN_BITS'(samp_cnt_q / DECIM);

  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    wr_idx_d   = wr_idx_q;
    keep       = 1'b0;
    frame_end  = 1'b0;
    set_short  = 1'b0;
    set_long   = 1'b0;
    unique case (state_q)
      ACTIVE: begin
        if (accept) begin
          if (samp_cnt_q == '0 && freeze) begin
            // Frame start under freeze: drop it; a single-sample frame needs no discard.
            if (!bus.s_last) state_d = DISCARD_FRZ;
          end else begin
            keep      = 1'b1;
            frame_end = bus.s_last | at_last_samp;
            if (frame_end) begin
              samp_cnt_d = '0;
              wr_idx_d   = (wr_idx_q == IDX_W'(NO_FFTS - 1)) ? '0 : wr_idx_q + 1'b1;
              set_short  = bus.s_last & ~at_last_samp;
              set_long   = ~bus.s_last;
              if (!bus.s_last) state_d = DISCARD_OVF;
            end else begin
              samp_cnt_d = samp_cnt_q + 1'b1;
            end
          end
        end
      end
      DISCARD_FRZ, DISCARD_OVF: begin
        if (accept && bus.s_last) state_d = ACTIVE;
      end
      default: state_d = ACTIVE;
    endcase
  end

  // wr_idx advances with the final write; the published index follows a cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ACTIVE;
      samp_cnt_q    <= '0;
      wr_idx_q      <= '0;
      oldest_q      <= '0;
      ready_q       <= 1'b0;
      commit_pend_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      samp_cnt_q    <= samp_cnt_d;
      wr_idx_q      <= wr_idx_d;
      ready_q       <= 1'b1;
      commit_pend_q <= keep & frame_end;
      frame_done_q  <= commit_pend_q;
      if (commit_pend_q) oldest_q <= wr_idx_q;
      if (set_short)    err_short_q <= 1'b1;
      else if (err_clr) err_short_q <= 1'b0;
      if (set_long)     err_long_q <= 1'b1;
      else if (err_clr) err_long_q <= 1'b0;
    end
  end

  peak_hold_group #(
    .IN_W           (IN_W),
    .DATAW          (DATAW),
    .SHIFT          (SHIFT),
    .DECIM          (DECIM),
    .BIN_BITS       (BIN_BITS),
    .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH),
    .NO_BANKS       (NO_BANKS),
    .IDX_W          (IDX_W)
  ) u_peak (
    .clk            (clk),
    .rst_n          (rst_n),
    .sample         (keep),
    .data           (bus.s_data),
    .frame_end      (frame_end),
    .bin            (bin),
    .wr_idx         (wr_idx_q),
    .wr_en          (bus.wr_en),
    .wr_bank_select (bus.wr_bank_select),
    .wr_address     (bus.wr_address),
    .wr_data        (bus.wr_data)
  );

  assign bus.s_ready    = ready_q;
  assign oldest_fft_idx = oldest_q;
  assign frame_done     = frame_done_q;
  assign err_short      = err_short_q;
  assign err_long       = err_long_q;

endmodule
